vga_line_buffer: RTL

Ping-pong line buffer feeding pixel colour to the VGA timing/pixel stage. An upstream pixel producer writes one scan line at a time through a valid/ready handshake. The timing stage pulls pixels out at the 25 MHz pixel rate using a line-start pulse and a per-pixel read strobe. Two line banks decouple producer burstiness from raster timing; underrun is flagged, never stalls the raster.

---
 rtl/vga_pkg.sv | 18 +
 rtl/vga_linebuf_ram.sv | 25 ++
 rtl/vga_line_buffer.sv | 100 ++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared line-buffer constants, rgb pixel type, pack helpers and writer state enum
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int PIX_W = 15;
  localparam int CH_W = 5;
  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;
  typedef enum logic {W_FILL, W_WAIT} wstate_t;
  function automatic rgb_t to_rgb(input logic [PIX_W-1:0] p);
    return rgb_t'(p);
  endfunction
  function automatic logic [PIX_W-1:0] from_rgb(input rgb_t c);
    return PIX_W'(c);
  endfunction
endpackage

// File: rtl/vga_linebuf_ram.sv
// vga_linebuf_ram: two-bank simple dual-port RAM, address {bank, offset}, registered read
module vga_linebuf_ram #(
  parameter int BANK_D = 640,
  parameter int W = 15,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  localparam int IW = $clog2(2 * BANK_D);
  logic [W-1:0] r_mem [2*BANK_D];
  logic [IW-1:0] w_widx, w_ridx;
  // bank bit selects the upper half so storage is exactly two banks deep
  assign w_widx = (i_waddr[AW-1] ? IW'(BANK_D) : '0) + IW'(i_waddr[AW-2:0]);
  assign w_ridx = (i_raddr[AW-1] ? IW'(BANK_D) : '0) + IW'(i_raddr[AW-2:0]);
  // one write port, one registered read port
  always_ff @(posedge clk) begin
    if (i_we) r_mem[w_widx] <= i_wdata;
    o_rdata <= r_mem[w_ridx];
  end
endmodule

// File: rtl/vga_line_buffer.sv
// vga_line_buffer: ping-pong line buffer between pixel producer and VGA raster; VGA_LINEBUF_REPEAT_EN replays the last line on underrun
module vga_line_buffer
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int PIX_W = vga_pkg::PIX_W
) (
  input  logic             clk_25,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_data,
  input  logic             in_last,
  input  logic             rd_line_start,
  input  logic             rd_en,
  output logic [4:0]       red,
  output logic [4:0]       green,
  output logic [4:0]       blue,
  output logic             underrun
);
`ifdef VGA_LINEBUF_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif
  localparam int OFF_W = $clog2(H_ACTIVE);
  localparam int RA_W = $clog2(H_ACTIVE + 1);
  wstate_t r_state, w_state_n;
  logic r_wb;
  logic [OFF_W-1:0] r_wa;
  logic [1:0] r_full;
  logic [RA_W-1:0] r_len [2];
  logic r_rb, r_rb_v, r_underrun, r_out_v;
  logic [RA_W-1:0] r_ra;
  logic w_beat, w_close, w_found, w_pick, w_release, w_rb_n, w_rb_v_n;
  logic [RA_W-1:0] w_ra_n;
  logic [PIX_W-1:0] w_q;
  rgb_t w_pix;
  assign w_beat = in_valid & in_ready;
  assign w_close = w_beat & (in_last | (r_wa == OFF_W'(H_ACTIVE - 1)));
  // writer state register
  always_ff @(posedge clk_25) r_state <= rst ? W_FILL : w_state_n;
  // writer next state: a closed line waits until the next bank is empty and not being displayed
  always_comb w_state_n = r_state == W_FILL ? (w_close ? W_WAIT : W_FILL)
                        : (!r_full[r_wb] && !(r_rb_v && r_rb == r_wb) ? W_FILL : W_WAIT);
  // writer output: accept pixels only while filling and out of reset
  always_comb in_ready = !rst && r_state == W_FILL;
  // reader bank selection at line start; when idle with both banks full, wb points at the older one
  always_comb begin
    w_pick = r_rb_v ? ~r_rb : (&r_full ? r_wb : r_full[1]);
    w_found = r_rb_v ? r_full[~r_rb] : |r_full;
    w_release = rd_line_start && r_rb_v && (w_found || !REPEAT);
    w_rb_n = rd_line_start && w_found ? w_pick : r_rb;
    w_rb_v_n = rd_line_start ? (w_found || (REPEAT && r_rb_v)) : r_rb_v;
    w_ra_n = rd_line_start ? '0 : r_ra;
  end
  // write pointer, bank full flags and line lengths; writer and reader touch different banks
  always_ff @(posedge clk_25) begin
    if (rst) begin
      r_wb <= 1'b0;
      r_wa <= '0;
      r_full <= '0;
      r_len[0] <= '0;
      r_len[1] <= '0;
    end else begin
      if (w_beat) r_wa <= w_close ? '0 : r_wa + 1'b1;
      if (w_close) begin
        r_wb <= ~r_wb;
        r_full[r_wb] <= 1'b1;
        r_len[r_wb] <= RA_W'(r_wa) + 1'b1;
      end
      if (w_release) r_full[r_rb] <= 1'b0;
    end
  end
  // reader bank, address, underrun pulse and output-valid qualifier aligned with the RAM read
  always_ff @(posedge clk_25) begin
    if (rst) begin
      {r_rb, r_rb_v, r_ra, r_underrun, r_out_v} <= '0;
    end else begin
      r_rb <= w_rb_n;
      r_rb_v <= w_rb_v_n;
      r_ra <= rd_en && w_ra_n != RA_W'(H_ACTIVE) ? w_ra_n + 1'b1 : w_ra_n;
      r_underrun <= rd_line_start && !w_found;
      r_out_v <= rd_en && w_rb_v_n && w_ra_n < r_len[w_rb_n];
    end
  end
  vga_linebuf_ram #(.BANK_D(H_ACTIVE), .W(PIX_W), .AW(OFF_W + 1)) u_ram (
    .clk     (clk_25),
    .i_we    (w_beat),
    .i_waddr ({r_wb, r_wa}),
    .i_wdata (in_data),
    .i_raddr ({w_rb_n, w_ra_n[OFF_W-1:0]}),
    .o_rdata (w_q)
  );
  assign w_pix = r_out_v ? to_rgb(w_q) : '0;
  assign red = w_pix.r;
  assign green = w_pix.g;
  assign blue = w_pix.b;
  assign underrun = r_underrun;
endmodule
